// File: rtl/ctrl_pkg.sv
// Shared constants and types for the control-cell front end: code word geometry,
// the NOP and write opcodes, and the sequencer state encoding.
package ctrl_pkg;

  localparam int BLOCK_BITS = 3;
  localparam int ADDR_BITS  = 6;
  localparam int MODE_BITS  = 2;
  localparam int TOC_WIDTH  = 4;
  localparam int BC         = (BLOCK_BITS + 1) * 2;
  localparam int CODE_W     = TOC_WIDTH + 2 * (BC + ADDR_BITS + MODE_BITS) + 1;

  localparam logic [CODE_W-1:0]    NOP_WORD = '0;
  localparam logic [TOC_WIDTH-1:0] OP_WRITE = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_t;

endpackage

// File: rtl/seq_fifo.sv
// Synchronous FIFO, combinational head read; 1-cycle push-to-visible latency.
// Backpressure: push ignored while full, pop ignored while empty.
module seq_fifo #(
  parameter int W     = 42,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cfg_sequencer.sv
// Buffers tagged code words and issues one per cycle to the control cell; first word 2 cycles after start.
// Backpressure: in_ready = !full only; stall inserts NOPs without consuming entries or repeats.
module cfg_sequencer
  import ctrl_pkg::*;
#(
  parameter int BLOCK_BITS = ctrl_pkg::BLOCK_BITS,
  parameter int ADDR_BITS  = ctrl_pkg::ADDR_BITS,
  parameter int MODE_BITS  = ctrl_pkg::MODE_BITS,
  parameter int TOC_WIDTH  = ctrl_pkg::TOC_WIDTH,
  parameter int CODE_W     = TOC_WIDTH + 2 * ((BLOCK_BITS + 1) * 2 + ADDR_BITS + MODE_BITS) + 1,
  parameter int DEPTH      = 8,
  parameter int REP_BITS   = 4,
  parameter int FLUSH_CYC  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic [REP_BITS-1:0] in_rep,
  input  logic                in_last,
  output logic [CODE_W-1:0]   code_out,
  output logic                busy,
  output logic                done,
  output logic                underrun,
  output logic [7:0]          issued
);

  localparam int ENT_W = CODE_W + REP_BITS + 1;
  localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  seq_state_t state, state_nxt;

  logic                full, empty, push, pop;
  logic                issue, start_run, set_underrun, done_nxt;
  logic [ENT_W-1:0]    wr_ent, head;
  logic [CODE_W-1:0]   head_code;
  logic [REP_BITS-1:0] head_rep;
  logic                head_last;
  logic [REP_BITS-1:0] rep_cnt;
  logic [FC_W-1:0]     flush_cnt;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign wr_ent   = {in_last, in_rep, in_code};
  assign {head_last, head_rep, head_code} = head;
  assign busy     = (state != IDLE);

  seq_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    start_run    = 1'b0;
    pop          = 1'b0;
    issue        = 1'b0;
    set_underrun = 1'b0;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !empty) begin
          state_nxt = RUN;
          start_run = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          if (empty) begin
            set_underrun = 1'b1;
          end else begin
            issue = 1'b1;
            // Compare before increment so rep = max still gives 2^REP_BITS issues.
            if (rep_cnt == head_rep) begin
              pop = 1'b1;
              if (head_last) state_nxt = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out  <= '0;
      done      <= 1'b0;
      underrun  <= 1'b0;
      issued    <= 8'd0;
      rep_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      code_out <= issue ? head_code : '0;
      done     <= done_nxt;
      if (start_run) begin
        issued   <= 8'd0;
        underrun <= 1'b0;
      end else begin
        if (issue)        issued   <= issued + 8'd1;
        if (set_underrun) underrun <= 1'b1;
      end
      if (issue) rep_cnt <= pop ? '0 : rep_cnt + 1'b1;
      // Held at zero outside FLUSH so it starts from zero on entry.
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer: a word-queue model checked every cycle plus literal expectations.
module tb_cfg_sequencer;
  import ctrl_pkg::*;

  localparam int DEPTH     = 8;
  localparam int REP_BITS  = 4;
  localparam int FLUSH_CYC = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                stall = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code = '0;
  logic [REP_BITS-1:0] in_rep = '0;
  logic                in_last = 1'b0;
  logic [CODE_W-1:0]   code_out;
  logic                busy, done, underrun;
  logic [7:0]          issued;

  int n_checks = 0;
  int n_err    = 0;

  cfg_sequencer #(
    .DEPTH     (DEPTH),
    .REP_BITS  (REP_BITS),
    .FLUSH_CYC (FLUSH_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stall    (stall),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .in_rep   (in_rep),
    .in_last  (in_last),
    .code_out (code_out),
    .busy     (busy),
    .done     (done),
    .underrun (underrun),
    .issued   (issued)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: every entry is expanded into rep+1 queued words; a program ends on the
  // last copy of a last-flagged entry, followed by a countdown of NOP cycles.
  typedef struct {
    logic [CODE_W-1:0] code;
    bit                entry_end;
    bit                prog_end;
  } mword_t;

  mword_t            mq[$];
  mword_t            mw;
  int                m_entries = 0;
  int                m_phase = 0;   // 0 idle, 1 issuing, 2 draining
  int                m_flush_left = 0;
  bit                m_accept;
  logic [CODE_W-1:0] e_code = '0;
  bit                e_done = 1'b0;
  bit                e_underrun = 1'b0;
  logic [7:0]        e_issued = 8'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_entries  = 0;
      m_phase    = 0;
      e_code     = NOP_WORD;
      e_done     = 1'b0;
      e_underrun = 1'b0;
      e_issued   = 8'd0;
    end else begin
      m_accept = in_valid && (m_entries < DEPTH);
      e_code   = NOP_WORD;
      e_done   = 1'b0;
      if (m_phase == 0) begin
        if (start && m_entries > 0) begin
          m_phase    = 1;
          e_issued   = 8'd0;
          e_underrun = 1'b0;
        end
      end else if (m_phase == 1) begin
        if (!stall) begin
          if (mq.size() == 0) begin
            e_underrun = 1'b1;
          end else begin
            mw       = mq.pop_front();
            e_code   = mw.code;
            e_issued = e_issued + 8'd1;
            if (mw.entry_end) m_entries--;
            if (mw.prog_end) begin
              m_phase      = 2;
              m_flush_left = FLUSH_CYC;
            end
          end
        end
      end else begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          e_done  = 1'b1;
          m_phase = 0;
        end
      end
      if (m_accept) begin
        for (int r = 0; r <= int'(in_rep); r++)
          mq.push_back('{in_code, (r == int'(in_rep)), in_last && (r == int'(in_rep))});
        m_entries++;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc.code_out", code_out, e_code);
    chk("cyc.done", done, e_done);
    chk("cyc.busy", busy, m_phase != 0);
    chk("cyc.underrun", underrun, e_underrun);
    chk("cyc.issued", issued, e_issued);
    chk("cyc.in_ready", in_ready, m_entries < DEPTH);
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push_entry(input logic [CODE_W-1:0] c, input logic [REP_BITS-1:0] r, input logic l);
    in_valid = 1'b1;
    in_code  = c;
    in_rep   = r;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic exp_cyc(input string tag, input logic [CODE_W-1:0] c, input bit d, input bit b);
    chk({tag, ".code"}, code_out, c);
    chk({tag, ".done"}, done, d);
    chk({tag, ".busy"}, busy, b);
  endtask

  task automatic exp_flush(input string tag);
    step(); exp_cyc({tag, ".nop0"}, NOP_WORD, 1'b0, 1'b1);
    step(); exp_cyc({tag, ".nop1"}, NOP_WORD, 1'b0, 1'b1);
    step(); exp_cyc({tag, ".nop2"}, NOP_WORD, 1'b1, 1'b0);
    step(); chk({tag, ".done_low"}, done, 1'b0);
  endtask

  function automatic logic [CODE_W-1:0] mk(input logic [31:0] v);
    return {OP_WRITE, v, 1'b1};
  endfunction

  initial begin
    step();
    step();
    chk("rst.code_out", code_out, NOP_WORD);
    chk("rst.busy", busy, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.issued", issued, 8'd0);
    rst = 1'b0;
    step();

    // Three single-shot entries.
    push_entry(mk(32'h11), 4'd0, 1'b0);
    push_entry(mk(32'h22), 4'd0, 1'b0);
    push_entry(mk(32'h33), 4'd0, 1'b1);
    pulse_start();
    exp_cyc("t1.gap", NOP_WORD, 1'b0, 1'b1);
    step(); exp_cyc("t1.a", mk(32'h11), 1'b0, 1'b1);
    step(); exp_cyc("t1.b", mk(32'h22), 1'b0, 1'b1);
    step(); exp_cyc("t1.c", mk(32'h33), 1'b0, 1'b1);
    exp_flush("t1");
    chk("t1.issued", issued, 8'd3);

    // One entry repeated three times.
    push_entry(mk(32'h44), 4'd2, 1'b1);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      step(); exp_cyc("t2.rep", mk(32'h44), 1'b0, 1'b1);
    end
    exp_flush("t2");
    chk("t2.issued", issued, 8'd3);

    // Stall for two cycles after the first of four issues.
    push_entry(mk(32'h55), 4'd3, 1'b1);
    pulse_start();
    step(); exp_cyc("t3.x0", mk(32'h55), 1'b0, 1'b1);
    stall = 1'b1;
    step(); exp_cyc("t3.stall0", NOP_WORD, 1'b0, 1'b1);
    step(); exp_cyc("t3.stall1", NOP_WORD, 1'b0, 1'b1);
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); exp_cyc("t3.x", mk(32'h55), 1'b0, 1'b1);
    end
    exp_flush("t3");
    chk("t3.issued", issued, 8'd4);

    // Underrun, then the program is completed by a late push.
    push_entry(mk(32'h66), 4'd0, 1'b0);
    pulse_start();
    step(); exp_cyc("t4.y", mk(32'h66), 1'b0, 1'b1);
    step(); exp_cyc("t4.empty0", NOP_WORD, 1'b0, 1'b1);
    chk("t4.underrun", underrun, 1'b1);
    step(); exp_cyc("t4.empty1", NOP_WORD, 1'b0, 1'b1);
    push_entry(mk(32'h77), 4'd0, 1'b1);
    exp_cyc("t4.pushed", NOP_WORD, 1'b0, 1'b1);
    step(); exp_cyc("t4.z", mk(32'h77), 1'b0, 1'b1);
    exp_flush("t4");
    chk("t4.issued", issued, 8'd2);
    chk("t4.underrun_sticky", underrun, 1'b1);

    // Fill to DEPTH, a refused ninth push, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      push_entry(mk(32'h80 + 32'(i)), 4'd0, (i == DEPTH - 1));
    chk("t5.full_ready", in_ready, 1'b0);
    push_entry(mk(32'hEE), 4'd0, 1'b1);
    chk("t5.refused_ready", in_ready, 1'b0);
    pulse_start();
    chk("t5.ready_before_pop", in_ready, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(); exp_cyc("t5.d", mk(32'h80 + 32'(i)), 1'b0, 1'b1);
      if (i == 0) chk("t5.ready_after_pop", in_ready, 1'b1);
    end
    exp_flush("t5");
    chk("t5.issued", issued, 8'd8);

    // Maximum repeat count gives sixteen issues.
    push_entry(mk(32'h99), 4'd15, 1'b1);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      step(); exp_cyc("t6.rep", mk(32'h99), 1'b0, 1'b1);
    end
    exp_flush("t6");
    chk("t6.issued", issued, 8'd16);

    // Reset in the middle of a program with four entries still pending.
    for (int i = 0; i < 5; i++)
      push_entry(mk(32'hA0 + 32'(i)), 4'd0, (i == 4));
    pulse_start();
    step(); exp_cyc("t7.first", mk(32'hA0), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("t7.rst_code", code_out, NOP_WORD);
    chk("t7.rst_busy", busy, 1'b0);
    chk("t7.rst_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    step(); exp_cyc("t7.ignored0", NOP_WORD, 1'b0, 1'b0);
    step(); exp_cyc("t7.ignored1", NOP_WORD, 1'b0, 1'b0);
    chk("t7.underrun", underrun, 1'b0);
    chk("t7.issued", issued, 8'd0);

    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
